// File: rtl/ucode_pkg.sv
// Shared definitions for the microsequencer: controlword layout, field encodings,
// opcode values, micro-state addresses and sequencer FSM states.
package ucode_pkg;

  localparam int CW_W = 25;

  localparam int ASRC_MSB    = 24, ASRC_LSB    = 22;
  localparam int ADEST_MSB   = 21, ADEST_LSB   = 20;
  localparam int BSRC_MSB    = 19, BSRC_LSB    = 17;
  localparam int BDEST_MSB   = 16, BDEST_LSB   = 14;
  localparam int ALU_MSB     = 13, ALU_LSB     = 11;
  localparam int MEMCNTL_MSB = 10, MEMCNTL_LSB = 8;
  localparam int IRECNTL_BIT = 7;
  localparam int NSSEL_MSB   = 6,  NSSEL_LSB   = 5;
  localparam int DBIN_MSB    = 4,  DBIN_LSB    = 0;

  typedef struct packed {
    logic [2:0] asrc;
    logic [1:0] adest;
    logic [2:0] bsrc;
    logic [2:0] bdest;
    logic [2:0] alu;
    logic [2:0] memcntl;
    logic       irecntl;
    logic [1:0] nssel;
    logic [4:0] dbin;
  } cw_t;

  typedef enum logic [1:0] {
    NS_DBIN = 2'b00,
    NS_OPC  = 2'b01,
    NS_MODE = 2'b10,
    NS_ZBR  = 2'b11
  } nssel_e;

  localparam logic [2:0] MEM_NONE = 3'b000;
  localparam logic [2:0] MEM_IRF  = 3'b010;

  localparam logic [3:0] OP_LDR  = 4'd0;
  localparam logic [3:0] OP_STR  = 4'd1;
  localparam logic [3:0] OP_OPR  = 4'd2;
  localparam logic [3:0] OP_POP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_BRZ  = 4'd5;
  localparam logic [3:0] OP_LDM  = 4'd6;
  localparam logic [3:0] OP_STM  = 4'd7;
  localparam logic [3:0] OP_OPM  = 4'd8;
  localparam logic [3:0] OP_TST  = 4'd9;

  localparam logic [4:0] start0 = 5'd0;
  localparam logic [4:0] abdm1  = 5'd1;
  localparam logic [4:0] brzz1  = 5'd9;
  localparam logic [4:0] ldrm1  = 5'd10;
  localparam logic [4:0] strm1  = 5'd11;
  localparam logic [4:0] oprm1  = 5'd12;
  localparam logic [4:0] test1  = 5'd14;
  localparam logic [4:0] ldrr1  = 5'd15;
  localparam logic [4:0] strr1  = 5'd16;
  localparam logic [4:0] oprr1  = 5'd17;
  localparam logic [4:0] popr1  = 5'd19;
  localparam logic [4:0] push1  = 5'd21;
  localparam logic [4:0] start1 = 5'd23;

  // Highest implemented micro-state; anything above is an illegal target.
  localparam logic [4:0] USTATE_LAST = 5'd23;

  localparam int WAIT_MAX_DEFAULT = 15;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/dispatch_decode.sv
// Opcode and mode dispatch tables; purely combinational, no state.
module dispatch_decode
  import ucode_pkg::*;
(
  input  logic [3:0] op,
  input  logic       mode_sel,
  output logic [4:0] target,
  output logic       bad
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned,
  // otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    target = start0;
    bad    = 1'b0;
    if (!mode_sel) begin
      case (op)
        OP_LDR:                         target = ldrr1;
        OP_STR:                         target = strr1;
        OP_OPR:                         target = oprr1;
        OP_POP:                         target = popr1;
        OP_PUSH:                        target = push1;
        OP_BRZ:                         target = brzz1;
        OP_LDM, OP_STM, OP_OPM, OP_TST: target = abdm1;
        default:                        bad    = 1'b1;
      endcase
    end else begin
      case (op)
        OP_LDM:  target = ldrm1;
        OP_STM:  target = strm1;
        OP_OPM:  target = oprm1;
        OP_TST:  target = test1;
        default: bad    = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Three-state microsequencer: FETCH covers control-store latency, EXEC/WAIT
// commit the current controlword and select the next micro-address.
module microsequencer
  import ucode_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] controlword,
  input  logic [3:0]  edb_op,
  input  logic        zflag,
  input  logic        mem_ready,
  output logic [4:0]  address,
  output logic        exec_en,
  output logic        illegal,
  output logic        timeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  cw_t cw;
  assign cw = controlword;

  // Datapath fields pass through to the datapath, not to sequencing.
  logic unused_cw_fields;
  assign unused_cw_fields = ^{cw.asrc, cw.adest, cw.bsrc, cw.bdest, cw.alu, cw.irecntl};

  seq_state_e       state_q, state_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;

  logic       mem_pending, ir_fetch;
  logic [3:0] op_eff;
  logic [4:0] disp_target;
  logic       disp_bad;
  logic [4:0] raw_next, next_addr;
  logic       next_bad;
  logic       commit, abort, bad_state;

  assign mem_pending = (cw.memcntl != MEM_NONE) && !mem_ready;
  assign ir_fetch    = (cw.memcntl == MEM_IRF);
  // Same-word IR fetch and dispatch must see the opcode arriving on the bus now.
  assign op_eff      = ir_fetch ? edb_op : op_q;

  dispatch_decode u_dispatch (
    .op       (op_eff),
    .mode_sel (cw.nssel == NS_MODE),
    .target   (disp_target),
    .bad      (disp_bad)
  );

  always_comb begin
    raw_next = cw.dbin;
    next_bad = 1'b0;
    case (cw.nssel)
      NS_DBIN: raw_next = cw.dbin;
      NS_OPC,
      NS_MODE: begin
        raw_next = disp_target;
        next_bad = disp_bad;
      end
      NS_ZBR:  raw_next = {cw.dbin[4:1], zflag};
      default: raw_next = cw.dbin;
    endcase
    next_addr = raw_next;
    if (raw_next > USTATE_LAST) begin
      next_addr = start0;
      next_bad  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    abort     = 1'b0;
    bad_state = 1'b0;
    case (state_q)
      FETCH: state_d = EXEC;
      EXEC: begin
        if (mem_pending) begin
          state_d = WAIT;
        end else begin
          commit  = 1'b1;
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (!mem_pending) begin
          commit  = 1'b1;
          state_d = FETCH;
        end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
          abort   = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        bad_state = 1'b1;
        state_d   = FETCH;
      end
    endcase
  end

  // A commit suppressed by reset must not reach the datapath either.
  assign exec_en = commit && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH;
      address  <= start0;
      op_q     <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        address <= next_addr;
      end else if (abort || bad_state) begin
        address <= start0;
      end
      if (commit && ir_fetch) begin
        op_q <= edb_op;
      end
      if (state_q == EXEC && state_d == WAIT) begin
        wait_cnt <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      illegal <= illegal || (commit && next_bad) || bad_state;
      timeout <= timeout || abort;
    end
  end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The module SHALL use a single clock and a synchronous, active-high reset.
REQ-002 Port: clock  in  1  rising-edge clock, shared with the control store.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: controlword  in  25  registered control-store output; fields: asrc[24:22], adest[21:20], bsrc[19:17], bdest[16:14], alu[13:11], memcntl[10:8], irecntl[7], nssel[6:5], dbin[4:0].
REQ-005 Port: edb_op  in  4  opcode field of the external data bus, sampled on an IR fetch.
REQ-006 Port: zflag  in  1  datapath zero flag.
REQ-007 Port: mem_ready  in  1  memory cycle complete.
REQ-008 Port: address  out  5  micro-PC, drives the control-store address.
REQ-009 Port: exec_en  out  1  datapath commit strobe for the current controlword.
REQ-010 Port: illegal  out  1  sticky flag for a bad opcode or an unused state.
REQ-011 Port: timeout  out  1  sticky flag for a memory wait overrun.
REQ-012 Parameter: WAIT_MAX, default 15, maximum number of WAIT cycles before abort.

Function
REQ-013 The FSM SHALL have three states: FETCH, EXEC and WAIT.
- FETCH always goes to EXEC. It covers the control-store read latency.
- In EXEC and WAIT, "mem pending" means memcntl != 000 and mem_ready = 0.
REQ-014 From EXEC, mem pending SHALL go to WAIT; otherwise the word commits.
REQ-015 WAIT SHALL commit on the first cycle with mem_ready = 1.
REQ-016 A commit cycle SHALL assert exec_en for exactly 1 cycle, load address <= next, and go to FETCH.
- exec_en is 0 in every other cycle.
REQ-017 Each microinstruction SHALL take 2 cycles, plus the number of WAIT cycles.
REQ-018 The next address SHALL be selected by nssel:
- 00: dbin.
- 01: opcode dispatch.
- 10: mode dispatch.
- 11: {dbin[4:1], zflag}.
REQ-019 Opcode dispatch table:
- 0 -> 15, 1 -> 16, 2 -> 17, 3 -> 19, 4 -> 21, 5 -> 9.
- 6, 7, 8, 9 -> 1.
- 10-15 -> 0, and set illegal.
REQ-020 Mode dispatch table:
- op 6 -> 10, 7 -> 11, 8 -> 12, 9 -> 14.
- Any other op -> 0, and set illegal.
REQ-021 The opcode latch SHALL load edb_op on a commit with memcntl = 010 (IR fetch).
REQ-022 When the same word both fetches the IR and dispatches (memcntl = 010 and nssel = 01 or 10), dispatch SHALL use edb_op (bypass), not the stale latch.
REQ-023 A computed next address of 24..31 SHALL be replaced by 0, and illegal SHALL be set.
REQ-024 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-025 When the wait counter reaches WAIT_MAX with mem_ready = 0:
- address <= 0 and state <= FETCH.
- exec_en stays 0 and timeout is set.
REQ-026 If mem_ready = 1 in the cycle the counter reaches WAIT_MAX, the word SHALL commit normally.
REQ-027 illegal and timeout SHALL only clear on reset.
- They do not block further sequencing.

Reset
REQ-028 On reset the outputs SHALL be:
- address = 0, exec_en = 0, illegal = 0, timeout = 0.
- Opcode latch = 0, wait counter = 0, state = FETCH.
REQ-029 Reset SHALL win over every other event, including reset asserted mid-WAIT or in a commit cycle.
REQ-030 In the first cycle after reset is released, the block SHALL be in FETCH at address 0.

Structure
REQ-031 The shared package ucode_pkg SHALL hold:
- Controlword field bit positions.
- nssel and memcntl encodings.
- Opcode values.
- Micro-state IDs: 0..23, named (start0 = 0, abdm1 = 1, brzz1 = 9, ldrm1 = 10, strm1 = 11, oprm1 = 12, test1 = 14, ldrr1 = 15, strr1 = 16, oprr1 = 17, popr1 = 19, push1 = 21, start1 = 23).
- WAIT_MAX default.
REQ-032 Both dispatch tables SHALL live in one combinational sub-module, dispatch_decode (inputs: op, mode_sel; outputs: target, bad).
- All state stays in microsequencer.

Verification
REQ-033 Reset, then cw = start0 word (memcntl 010, nssel 00, dbin 23), edb_op = 2, mem_ready = 1 -> address 0 for 2 cycles, one exec_en pulse, then address 23 with latch = 2.
REQ-034 Latch = 2, cw nssel 01 -> next address 17. Repeat for op 12 -> address 0, illegal = 1.
REQ-035 cw nssel 11, dbin 6: zflag = 0 -> address 6; zflag = 1 -> address 7.
REQ-036 cw memcntl 001 with mem_ready held low for 3 cycles -> 3 WAIT cycles, then exec_en on the 4th EXEC/WAIT cycle; address advances only at commit.
REQ-037 mem_ready held low for more than 15 cycles -> address 0, timeout = 1, no exec_en pulse.
- Then assert reset mid-WAIT -> all REQ-028 values on the next edge.
REQ-038 cw nssel 00 with dbin 27 -> address 0 and illegal = 1.
- Same-word IR fetch plus dispatch with edb_op = 4 and an old latch of 0 -> address 21.
